mod_enc_mixcolumns: RTL and testbench

Encryption-path MixColumns stage of the AES-256 core. It sits directly downstream of the ShiftRows row shifters and takes the full 16-byte state once all four rows have been shifted. It multiplies each column by the fixed GF(2^8) matrix, handling one column per clock. The mixed state is handed to the AddRoundKey stage through a valid/ready handshake.

---
 rtl/mod_enc_mixcolumns.sv | 115 +++++++++++
 tb/tb_mod_enc_mixcolumns.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_enc_mixcolumns.sv
// AES-256 encryption MixColumns stage: mixes one column per clock, valid/ready on both sides.
// Optional final-round bypass input enabled by defining ENC_MIXCOL_BYPASS_EN.
module mod_enc_mixcolumns (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0][7:0] inp,
`ifdef ENC_MIXCOL_BYPASS_EN
  input  logic             bypass,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0][7:0] outp,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [1:0]      col_cnt;
  logic [15:0][7:0] buffer;
  logic            bypass_q;
  logic [3:0][7:0] col_in;
  logic [3:0][7:0] col_mix;
  logic [3:0][7:0] col_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (col_cnt == 2'd3) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Column col_cnt of the row-major buffer lives at bytes 4*r + col_cnt.
  always_comb begin
    col_in[0] = buffer[{2'd0, col_cnt}];
    col_in[1] = buffer[{2'd1, col_cnt}];
    col_in[2] = buffer[{2'd2, col_cnt}];
    col_in[3] = buffer[{2'd3, col_cnt}];

    col_mix[0] = xtime(col_in[0]) ^ xtime(col_in[1]) ^ col_in[1] ^ col_in[2] ^ col_in[3];
    col_mix[1] = col_in[0] ^ xtime(col_in[1]) ^ xtime(col_in[2]) ^ col_in[2] ^ col_in[3];
    col_mix[2] = col_in[0] ^ col_in[1] ^ xtime(col_in[2]) ^ xtime(col_in[3]) ^ col_in[3];
    col_mix[3] = xtime(col_in[0]) ^ col_in[0] ^ col_in[1] ^ col_in[2] ^ xtime(col_in[3]);

    col_out = bypass_q ? col_in : col_mix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer  <= '0;
      col_cnt <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            buffer  <= inp;
            col_cnt <= 2'd0;
          end
        end
        CALC: begin
          buffer[{2'd0, col_cnt}] <= col_out[0];
          buffer[{2'd1, col_cnt}] <= col_out[1];
          buffer[{2'd2, col_cnt}] <= col_out[2];
          buffer[{2'd3, col_cnt}] <= col_out[3];
          col_cnt                 <= col_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef ENC_MIXCOL_BYPASS_EN
  always_ff @(posedge clk) begin
    if (rst)                          bypass_q <= 1'b0;
    else if (state == IDLE && in_valid) bypass_q <= bypass;
  end
`else
  assign bypass_q = 1'b0;
`endif

  assign outp = buffer;

endmodule

// File: tb/tb_mod_enc_mixcolumns.sv
// Self-checking bench for mod_enc_mixcolumns against a GF(2^8) matrix reference model.
module tb_mod_enc_mixcolumns;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0][7:0] inp;
`ifdef ENC_MIXCOL_BYPASS_EN
  logic             bypass;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [15:0][7:0] outp;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  mod_enc_mixcolumns dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp       (inp),
`ifdef ENC_MIXCOL_BYPASS_EN
    .bypass    (bypass),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outp      (outp),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // General GF(2^8) product, reduced by the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [15:0][7:0] refMix(input logic [15:0][7:0] s, input bit byp);
    int mtx [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
    logic [15:0][7:0] r;
    logic [7:0] acc;
    r = s;
    if (!byp) begin
      for (int c = 0; c < 4; c++) begin
        for (int row = 0; row < 4; row++) begin
          acc = 8'h00;
          for (int k = 0; k < 4; k++) acc = acc ^ gmul(8'(mtx[row][k]), s[4*k+c]);
          r[4*row+c] = acc;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0][7:0] fromCols(input logic [31:0] c0, input logic [31:0] c1,
                                                 input logic [31:0] c2, input logic [31:0] c3);
    logic [15:0][7:0] s;
    for (int row = 0; row < 4; row++) begin
      s[4*row+0] = c0[31-8*row -: 8];
      s[4*row+1] = c1[31-8*row -: 8];
      s[4*row+2] = c2[31-8*row -: 8];
      s[4*row+3] = c3[31-8*row -: 8];
    end
    return s;
  endfunction

  function automatic logic [15:0][7:0] randState();
    logic [15:0][7:0] s;
    for (int i = 0; i < 16; i++) s[i] = 8'($urandom);
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents st at a negedge in IDLE and steps to the negedge where out_valid should first be high.
  task automatic applyStimulus(input logic [15:0][7:0] st, input string tag);
    inp      = st;
    in_valid = 1'b1;
    checkOutput({tag, "_in_ready"}, 128'(in_ready), 128'(1'b1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    inp      = randState();
    checkOutput({tag, "_calc_busy"}, 128'({out_valid, busy}), 128'(2'b01));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_lat%0d", tag, k + 2), 128'(out_valid), 128'(1'b0));
    end
    @(negedge clk);
    checkOutput({tag, "_out_valid"}, 128'(out_valid), 128'(1'b1));
  endtask

  task automatic completeHandshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_hs_idle"}, 128'({in_ready, out_valid, busy}), 128'(3'b100));
  endtask

  logic [15:0][7:0] st;
  logic [15:0][7:0] held;
  logic [15:0][7:0] b2b [3];
  int acc_cyc [3];
  int nacc;
  int nout;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inp       = '0;
`ifdef ENC_MIXCOL_BYPASS_EN
    bypass    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    checkOutput("reset_outp", outp, 128'h0);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 example column
    st = fromCols(32'hd4bf5d30, 32'h01010101, 32'h01010101, 32'h01010101);
    applyStimulus(st, "fips");
    checkOutput("fips_const", outp, fromCols(32'h046681e5, 32'h01010101, 32'h01010101, 32'h01010101));
    checkOutput("fips_model", outp, refMix(st, 1'b0));
    completeHandshake("fips");

    st = fromCols(32'hf20a225c, 32'hc6c6c6c6, 32'hdb135345, 32'h00000000);
    applyStimulus(st, "known");
    checkOutput("known_const", outp, fromCols(32'h9fdc589d, 32'hc6c6c6c6, 32'h8e4da1bc, 32'h00000000));
    completeHandshake("known");

    for (int n = 0; n < 4; n++) begin
      st = randState();
      applyStimulus(st, $sformatf("rand%0d", n));
      checkOutput($sformatf("rand%0d_outp", n), outp, refMix(st, 1'b0));
      completeHandshake($sformatf("rand%0d", n));
    end

    // Backpressure: output held, second request must be ignored.
    out_ready = 1'b0;
    st = randState();
    applyStimulus(st, "bp");
    held = refMix(st, 1'b0);
    for (int k = 0; k < 10; k++) begin
      in_valid = (k == 3);
      inp      = randState();
      checkOutput($sformatf("bp_hold%0d", k), outp, held);
      checkOutput($sformatf("bp_flags%0d", k), 128'({in_ready, out_valid}), 128'(2'b01));
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("bp_final", outp, held);
    completeHandshake("bp");

    // Back-to-back with both valid and ready held high.
    for (int i = 0; i < 3; i++) b2b[i] = randState();
    nacc = 0;
    nout = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      in_valid = (nacc < 3);
      if (nacc < 3) inp = b2b[nacc];
      if (out_valid) begin
        if (nout < 3) checkOutput($sformatf("b2b_out%0d", nout), outp, refMix(b2b[nout], 1'b0));
        else          checkOutput("b2b_extra_out", 128'(out_valid), 128'(1'b0));
        nout++;
      end
      if (in_ready && in_valid) begin
        acc_cyc[nacc] = cyc;
        nacc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("b2b_accepts", 128'(nacc), 128'(3));
    checkOutput("b2b_outputs", 128'(nout), 128'(3));
    checkOutput("b2b_gap01", 128'(acc_cyc[1] - acc_cyc[0]), 128'(6));
    checkOutput("b2b_gap12", 128'(acc_cyc[2] - acc_cyc[1]), 128'(6));

    // Reset during the second CALC cycle.
    inp      = randState();
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    checkOutput("rst_outp", outp, 128'h0);
    rst = 1'b0;
    st = randState();
    applyStimulus(st, "post_rst");
    checkOutput("post_rst_outp", outp, refMix(st, 1'b0));
    completeHandshake("post_rst");

`ifdef ENC_MIXCOL_BYPASS_EN
    for (int i = 0; i < 16; i++) st[i] = 8'(i);
    bypass = 1'b1;
    applyStimulus(st, "bypass");
    bypass = 1'b0;
    checkOutput("bypass_outp", outp, 128'h0f0e0d0c0b0a09080706050403020100);
    completeHandshake("bypass");
    st = randState();
    applyStimulus(st, "after_bypass");
    checkOutput("after_bypass_outp", outp, refMix(st, 1'b0));
    completeHandshake("after_bypass");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
